display_scan_4dig: RTL and testbench
====================================

# display_scan_4dig

Four-digit multiplexed 7-segment scanner that sits directly downstream of the counter in the TinyTapeout top level. It accepts a 16-bit BCD/hex value plus decimal points and shows one digit at a time. The active digit advances at a programmable refresh rate, and new values are shadowed so they take effect only at frame boundaries. Its outputs drive `segmentos[7:0]` (to `uo_out`) and `sel_seg[3:0]` (to `uio_out[7:4]`) directly.

## Interface

Parameters:
- `REFRESH_DIV`, default 12500: clock cycles per digit slot. Legal range is ≥2. The prescaler width is `$clog2(REFRESH_DIV)`.

Ports:
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `bcd_in`, input, 16: value to show. Nibble *k* maps to digit *k*, and digit 0 is the rightmost.
- `dp_in`, input, 4: decimal-point enables, one bit per digit.
- `load`, input, 1: capture request. Samples `{dp_in, bcd_in}` on every cycle it is high.
- `blank`, input, 1: forces the display dark while high.
- `segmentos`, output, 8: active-high segments. Bits [6:0] are a..g; bit 7 is dp. Registered.
- `sel_seg`, output, 4: one-hot, active-high digit select. Registered.
- `frame_done`, output, 1: one-cycle pulse per completed frame. Registered.

## Operation

- **Prescaler `pre`:** counts 0..REFRESH_DIV-1 and wraps. `tick` is defined as `pre == REFRESH_DIV-1`.
- **Digit pointer `ptr[1:0]`:** increments on `tick` and wraps 3→0.
- **Frame boundary:** `tick && ptr == 3`.
- **Pending register `{pdp, pval}`:** loaded from `{dp_in, bcd_in}` on any cycle with `load` high. The last load before a boundary wins.
- **Display register `{ddp, dval}`:** updated only at a frame boundary.
  - Source is `{dp_in, bcd_in}` when `load` is high on the boundary cycle.
  - Otherwise the source is `{pdp, pval}`.
  - No tearing: all four digits of one frame always come from the same value.
- **Output registers:** updated every cycle from the current state.
  - `sel_seg <= blank ? 4'b0000 : (4'b0001 << ptr)`.
  - `segmentos <= blank ? 8'h00 : {ddp[ptr], glyph(dval[4*ptr +: 4])}`.
- **Glyph table (bits g..a):**
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F
  - A:77, b:7C, C:39, d:5E, E:79, F:71
  - Non-BCD nibbles are displayed as hex; they are not an error.
- **Effect of `blank`:** it does not stop `pre` or `ptr`, and it does not block loads or frame updates.
- **`frame_done`:** set to 1 on the edge where a frame boundary occurs, and to 0 on every other edge.

## Timing

- **Reset values:**
  - `pre = 0`, `ptr = 0`.
  - `pval = dval = 16'h0000`, `pdp = ddp = 4'b0000`.
  - `segmentos = 8'h00`, `sel_seg = 4'b0000`, `frame_done = 0`.
- **First cycle after reset release:** `sel_seg = 0001`, `segmentos = 8'h3F`.
- **Output latency:** one cycle from any `ptr`, `dval` or `blank` change to the outputs.
- **Digit dwell:** each digit is shown for exactly REFRESH_DIV cycles. A full frame is 4×REFRESH_DIV cycles.
- **Boundary edge E:**
  - `ptr`, `dval` and `ddp` change at E.
  - `frame_done` is high in the cycle after E.
  - The outputs show the new digit 0 from edge E+1 onward.
- **Value latency:** from a `load` to its first visible digit is at most 4×REFRESH_DIV + 1 cycles.
- **Reset mid-frame:** every register returns to its reset value on the next edge, and any pending load is discarded.

## Configuration

- **`LEADING_ZERO_BLANK_EN` defined:**
  - Digits 3..1 have their a..g segments forced to 0 when that digit and every higher digit of `dval` are 0.
  - Digit 0 is never blanked.
  - The dp bit and `sel_seg` are unaffected.
- **Macro undefined:** every digit shows its glyph, so zero is shown as "0".

## Test plan

All scenarios use REFRESH_DIV=4.

- **Reset:** pulse `rst`, then release.
  - Cycle 1: `sel_seg = 0001`, `segmentos = 3F`.
  - `sel_seg` walks 0010, 0100, 1000 every 4 cycles.
  - `frame_done` pulses once per 16 cycles.
- **Shadowed load:** `load` 0x1234 with `dp_in = 0100` in the middle of a frame.
  - The remaining digits of that frame still show 3F.
  - From the next frame: digit 0 = 66, digit 1 = 4F, digit 2 = DB (5B with dp), digit 3 = 06.
- **Load on the boundary cycle:** `load` 0x0009 exactly on the boundary cycle.
  - Digit 0 shows 6F from edge E+1.
  - An earlier pending value in the same frame is discarded.
- **Hex glyphs:** value 0x00AF (macro off).
  - digit 0 = 71, digit 1 = 77, digits 2 and 3 = 3F.
- **Blank mid-digit:** assert `blank` for 3 cycles in the middle of a digit.
  - Outputs are 00/0000 one cycle later.
  - On release, the pointer shows that scanning continued (the correct digit resumes).
- **`LEADING_ZERO_BLANK_EN` defined:**
  - Value 0x0042: digits 3 and 2 give `segmentos = 00` with `sel_seg` still asserted; digit 1 = 66, digit 0 = 5B.
  - Value 0x0000: digit 0 = 3F and the other digits are 00.

Source files
------------

// File: rtl/display_scan_4dig.sv
// -----------------------------------------------------------------------------
// display_scan_4dig
//   Four-digit multiplexed 7-segment scanner. One digit is lit at a time and
//   the active digit advances every REFRESH_DIV clocks. New values are written
//   to a pending register and reach the display register only at a frame
//   boundary, so a frame never mixes digits from two different values.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digits 3..1 suppress their a..g segments if that digit and
//   every more significant digit are zero. Digit 0 is never suppressed.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   bcd_in      in   16-bit value, nibble k -> digit k (digit 0 rightmost)
//   dp_in       in   decimal point enables, one bit per digit
//   load        in   capture {dp_in, bcd_in} into the pending register
//   blank       in   force the display dark (scanning continues)
//   segmentos   out  registered active-high segments, [6:0]=a..g, [7]=dp
//   sel_seg     out  registered one-hot active-high digit select
//   frame_done  out  registered one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
module display_scan_4dig #(
  parameter int REFRESH_DIV = 12500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank,
  output logic [7:0]  segmentos,
  output logic [3:0]  sel_seg,
  output logic        frame_done
);

  localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  // Segment pattern (g..a) for a nibble; values above 9 are shown as hex.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Nibble of the display value belonging to digit ptr.
  function automatic logic [3:0] nibble_sel(input logic [15:0] val, input logic [1:0] ptr);
    logic [3:0] nib;
    case (ptr)
      2'd0:    nib = val[3:0];
      2'd1:    nib = val[7:4];
      2'd2:    nib = val[11:8];
      2'd3:    nib = val[15:12];
      default: nib = val[3:0];
    endcase
    return nib;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit ptr and all digits above it are zero; digit 0 always shows.
  function automatic logic leading_zero(input logic [15:0] val, input logic [1:0] ptr);
    logic lz;
    case (ptr)
      2'd0:    lz = 1'b0;
      2'd1:    lz = (val[15:4] == 12'h000);
      2'd2:    lz = (val[15:8] == 8'h00);
      2'd3:    lz = (val[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction
`endif

  logic [PW-1:0] r_pre;
  logic [1:0]    r_ptr;
  logic [15:0]   r_pval;
  logic [3:0]    r_pdp;
  logic [15:0]   r_dval;
  logic [3:0]    r_ddp;

  logic          w_tick;
  logic          w_boundary;
  logic [6:0]    w_glyph;
  logic [7:0]    w_seg_next;
  logic [3:0]    w_sel_next;

  // Slot/frame timing and the next-cycle output pattern for the current digit.
  always_comb begin
    w_tick     = (r_pre == PRE_LAST);
    w_boundary = w_tick && (r_ptr == 2'd3);
    w_glyph    = glyph(nibble_sel(r_dval, r_ptr));
`ifdef LEADING_ZERO_BLANK_EN
    if (leading_zero(r_dval, r_ptr)) begin
      w_glyph = 7'h00;
    end else begin
      w_glyph = glyph(nibble_sel(r_dval, r_ptr));
    end
`endif
    if (blank) begin
      w_seg_next = 8'h00;
      w_sel_next = 4'b0000;
    end else begin
      w_seg_next = {r_ddp[r_ptr], w_glyph};
      w_sel_next = 4'b0001 << r_ptr;
    end
  end

  // Prescaler, digit pointer, pending/display registers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre      <= '0;
      r_ptr      <= 2'd0;
      r_pval     <= 16'h0000;
      r_pdp      <= 4'b0000;
      r_dval     <= 16'h0000;
      r_ddp      <= 4'b0000;
      segmentos  <= 8'h00;
      sel_seg    <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      if (w_tick) begin
        r_pre <= '0;
        r_ptr <= r_ptr + 2'd1;
      end else begin
        r_pre <= r_pre + PRE_ONE;
      end

      if (load) begin
        r_pval <= bcd_in;
        r_pdp  <= dp_in;
      end

      // A load on the boundary cycle bypasses the pending register.
      if (w_boundary) begin
        if (load) begin
          r_dval <= bcd_in;
          r_ddp  <= dp_in;
        end else begin
          r_dval <= r_pval;
          r_ddp  <= r_pdp;
        end
      end

      segmentos  <= w_seg_next;
      sel_seg    <= w_sel_next;
      frame_done <= w_boundary;
    end
  end

endmodule

// File: tb/tb_display_scan_4dig.sv
// -----------------------------------------------------------------------------
// tb_display_scan_4dig
//   Self-checking bench for display_scan_4dig with REFRESH_DIV = 4. A
//   reference model tracks elapsed cycles since reset and derives the digit
//   slot and frame position arithmetically; directed steps check the key
//   scenarios against literal values, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_display_scan_4dig;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [7:0]  segmentos;
  logic [3:0]  sel_seg;
  logic        frame_done;

  display_scan_4dig #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .segmentos  (segmentos),
    .sel_seg    (sel_seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          t;          // cycles since reset release
  logic [15:0] m_pval, m_dval;
  logic [3:0]  m_pdp, m_ddp;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_fd;
  logic [6:0]  glyph_tab [0:15];
  int          fd_count;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 after.
  task automatic step(input logic r, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic b);
    int ptr;
    int nib;
    logic bnd;
    rst = r; load = l; bcd_in = v; dp_in = d; blank = b;
    @(posedge clk);
    if (r) begin
      t = 0;
      m_pval = 16'h0000; m_dval = 16'h0000;
      m_pdp = 4'b0000;   m_ddp = 4'b0000;
      exp_seg = 8'h00; exp_sel = 4'b0000; exp_fd = 1'b0;
    end else begin
      ptr = (t / DIV) % 4;
      bnd = ((t % (4 * DIV)) == (4 * DIV - 1));
      nib = int'((m_dval >> (4 * ptr)) & 16'h000F);
      if (b) begin
        exp_seg = 8'h00;
        exp_sel = 4'b0000;
      end else begin
        exp_sel = 4'(1 << ptr);
        exp_seg = {m_ddp[ptr], glyph_tab[nib]};
`ifdef LEADING_ZERO_BLANK_EN
        if (ptr != 0 && (m_dval >> (4 * ptr)) == 16'h0000) exp_seg[6:0] = 7'h00;
`endif
      end
      exp_fd = bnd;
      if (l) begin m_pval = v; m_pdp = d; end
      if (bnd) begin
        m_dval = l ? v : m_pval;
        m_ddp  = l ? d : m_pdp;
      end
      t++;
    end
    #1;
    chk("segmentos", segmentos, exp_seg);
    chk("sel_seg", {4'h0, sel_seg}, {4'h0, exp_sel});
    chk("frame_done", {7'h00, frame_done}, {7'h00, exp_fd});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  // Idle until the model's frame phase (before the next edge) equals ph.
  task automatic align(input int ph);
    for (int i = 0; i < 4 * DIV && (t % (4 * DIV)) != ph; i++) idle();
  endtask

  // Step to the start of each digit slot of the next frame and check literals.
  task automatic check_frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    align(0);
    idle(); chk({tag, "_d0"}, segmentos, d0); chk({tag, "_s0"}, {4'h0, sel_seg}, 8'h01);
    adv(DIV - 1);
    idle(); chk({tag, "_d1"}, segmentos, d1); chk({tag, "_s1"}, {4'h0, sel_seg}, 8'h02);
    adv(DIV - 1);
    idle(); chk({tag, "_d2"}, segmentos, d2); chk({tag, "_s2"}, {4'h0, sel_seg}, 8'h04);
    adv(DIV - 1);
    idle(); chk({tag, "_d3"}, segmentos, d3); chk({tag, "_s3"}, {4'h0, sel_seg}, 8'h08);
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    t = 0;
    m_pval = 16'h0000; m_dval = 16'h0000; m_pdp = 4'b0000; m_ddp = 4'b0000;
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0000; dp_in = 4'b0000; blank = 1'b0;

    // Reset, then first cycle shows digit 0 of zero
    step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    chk("reset_seg", segmentos, 8'h00);
    chk("reset_sel", {4'h0, sel_seg}, 8'h00);
    idle();
    chk("first_sel", {4'h0, sel_seg}, 8'h01);
    chk("first_seg", segmentos, 8'h3F);
    adv(DIV - 1);
    idle(); chk("walk_1", {4'h0, sel_seg}, 8'h02);
    adv(DIV - 1);
    idle(); chk("walk_2", {4'h0, sel_seg}, 8'h04);
    adv(DIV - 1);
    idle(); chk("walk_3", {4'h0, sel_seg}, 8'h08);

    // frame_done pulses once per 16 cycles
    fd_count = 0;
    for (int i = 0; i < 8 * DIV; i++) begin
      idle();
      if (frame_done) fd_count++;
    end
    chk("fd_count", 8'(fd_count), 8'd2);

    // Shadowed load in mid-frame
    align(6);
    step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(); chk("shadow_old", segmentos, 8'h3F);
    check_frame("shadow", 8'h66, 8'h4F, 8'hDB, 8'h06);

    // Load on the boundary cycle overrides an earlier pending value
    align(3);
    step(1'b0, 1'b1, 16'h0777, 4'b0000, 1'b0);
    align(4 * DIV - 1);
    step(1'b0, 1'b1, 16'h0009, 4'b0000, 1'b0);
    idle(); chk("bnd_load_d0", segmentos, 8'h6F);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("bnd_load", 8'h6F, 8'h00, 8'h00, 8'h00);
`else
    check_frame("bnd_load", 8'h6F, 8'h3F, 8'h3F, 8'h3F);
`endif

    // Hex glyphs
    align(8);
    step(1'b0, 1'b1, 16'h00AF, 4'b0000, 1'b0);
    align(0); adv(1);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("hex", 8'h71, 8'h77, 8'h00, 8'h00);
`else
    check_frame("hex", 8'h71, 8'h77, 8'h3F, 8'h3F);
`endif

    // Blank for 3 cycles mid-digit; scanning continues underneath
    align(5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1);
      chk("blank_seg", segmentos, 8'h00);
      chk("blank_sel", {4'h0, sel_seg}, 8'h00);
    end
    idle(); chk("blank_resume", {4'h0, sel_seg}, 8'h04);

    // Leading-zero cases
    align(2);
    step(1'b0, 1'b1, 16'h0042, 4'b0000, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("lz42", 8'h5B, 8'h66, 8'h00, 8'h00);
`else
    check_frame("lz42", 8'h5B, 8'h66, 8'h3F, 8'h3F);
`endif
    align(2);
    step(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("lz00", 8'h3F, 8'h00, 8'h00, 8'h00);
`else
    check_frame("lz00", 8'h3F, 8'h3F, 8'h3F, 8'h3F);
`endif

    // Reset mid-frame discards a pending load
    align(5);
    step(1'b0, 1'b1, 16'h8888, 4'b1111, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    chk("midrst_seg", segmentos, 8'h00);
    check_frame("midrst", 8'h3F, 8'h3F, 8'h3F, 8'h3F);

    // Randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
